// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: stall vectors, FSM states, common words.
package pipe_ctrl_pkg;

  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam logic RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    CTRL_RUN  = 1'b0,
    CTRL_HOLD = 1'b1
  } ctrl_state_t;

  // The deepest requesting stage freezes itself and everything upstream of it.
  function automatic logic [5:0] stall_merge(input logic req_id, input logic req_ex,
                                             input logic req_mem);
    if (req_mem)     return STALL_MEM;
    else if (req_ex) return STALL_EX;
    else if (req_id) return STALL_ID;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests, sequences exception flushes,
// and keeps a stall watchdog plus a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             excp_valid,
  input  logic [31:0]      excp_pc,
  input  logic             clr_stats,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output ctrl_state_t      dbg_state
);

  localparam int unsigned RUN_W = (STALL_TIMEOUT > 2) ? $clog2(STALL_TIMEOUT) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_TIMEOUT - 1);

  ctrl_state_t      state, state_next;
  logic [RUN_W-1:0] run_cnt;
  logic             stall_active;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state <= CTRL_RUN;
    else                   state <= state_next;
  end

  // Outputs are combinational so the stage registers see them at the same edge.
  always_comb begin
    stall      = stall_merge(stallreq_id, stallreq_ex, stallreq_mem);
    flush      = 1'b0;
    new_pc     = ZERO_WORD;
    state_next = CTRL_RUN;
    if (rst == RST_ENABLE) begin
      stall = STALL_NONE;
    end else begin
      case (state)
        CTRL_RUN: begin
          // A mem stall blocks the exception; mem keeps presenting it.
          if (excp_valid && !stallreq_mem) begin
            flush      = 1'b1;
            new_pc     = excp_pc;
            stall      = STALL_NONE;
            state_next = CTRL_HOLD;
          end
        end
        CTRL_HOLD: state_next = CTRL_RUN;
        default:   state_next = CTRL_RUN;
      endcase
    end
  end

  assign stall_active = (stall != STALL_NONE);
  assign dbg_state    = state;

  // run_cnt parks at RUN_MAX so a long stall cannot wrap it.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      run_cnt       <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (!stall_active || flush)  run_cnt <= '0;
      else if (run_cnt != RUN_MAX) run_cnt <= run_cnt + RUN_W'(1);

      if (clr_stats)                              stall_timeout <= 1'b0;
      else if (stall_active && run_cnt == RUN_MAX) stall_timeout <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_stats),
    .inc   (stall_active),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a short watchdog (4) and a 3-bit stall counter.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic        excp_valid = 1'b0;
  logic [31:0] excp_pc = 32'h0;
  logic        clr_stats = 1'b0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [2:0]  stall_cycles;
  ctrl_state_t dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  pipe_ctrl #(.STALL_TIMEOUT(4), .CNT_W(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .excp_valid    (excp_valid),
    .excp_pc       (excp_pc),
    .clr_stats     (clr_stats),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_timeout (stall_timeout),
    .stall_cycles  (stall_cycles),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic ex, input logic mem);
    stallreq_id  = id;
    stallreq_ex  = ex;
    stallreq_mem = mem;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_timeout", 32'(stall_timeout), 32'h0);
    chk("rst_cycles", 32'(stall_cycles), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(CTRL_RUN));
    rst = 1'b0;
    tick();

    // Stall priority: 3 stalled cycles then release
    set_req(1, 0, 0); #1; chk("prio_id", 32'(stall), 32'h07); tick();
    set_req(1, 1, 0); #1; chk("prio_ex", 32'(stall), 32'h0f); tick();
    set_req(1, 1, 1); #1; chk("prio_mem", 32'(stall), 32'h1f); tick();
    set_req(0, 0, 0); #1; chk("prio_none", 32'(stall), 32'h00); tick();
    chk("gap_no_timeout", 32'(stall_timeout), 32'h0);
    chk("cycles_3", 32'(stall_cycles), 32'd3);
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    chk("clr_cycles", 32'(stall_cycles), 32'd0);

    // Exception in RUN beats an ex stall request
    excp_valid = 1'b1; excp_pc = 32'h0000_0020; set_req(0, 1, 0); #1;
    chk("excp_flush", 32'(flush), 32'h1);
    chk("excp_new_pc", new_pc, 32'h20);
    chk("excp_stall", 32'(stall), 32'h0);
    tick();
    excp_valid = 1'b0; set_req(0, 0, 0); #1;
    chk("hold_flush", 32'(flush), 32'h0);
    chk("hold_new_pc", new_pc, 32'h0);
    chk("hold_state", 32'(dbg_state), 32'(CTRL_HOLD));
    tick();
    chk("back_run", 32'(dbg_state), 32'(CTRL_RUN));

    // Exception blocked by mem stall for 3 cycles, then taken
    excp_valid = 1'b1; excp_pc = 32'h0000_0040; set_req(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("blk_flush", 32'(flush), 32'h0);
      chk("blk_stall", 32'(stall), 32'h1f);
      tick();
    end
    set_req(0, 0, 0); #1;
    chk("unblk_flush", 32'(flush), 32'h1);
    chk("unblk_new_pc", new_pc, 32'h40);
    tick();
    // excp_valid still high in HOLD: ignored
    #1;
    chk("b2b_flush", 32'(flush), 32'h0);
    chk("b2b_new_pc", new_pc, 32'h0);
    excp_valid = 1'b0;
    tick();
    chk("blk_no_timeout", 32'(stall_timeout), 32'h0);
    chk("blk_cycles", 32'(stall_cycles), 32'd3);

    // Watchdog: 4 consecutive stalled cycles trip it
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    set_req(1, 0, 0);
    tick(); tick(); tick();
    chk("wd_3", 32'(stall_timeout), 32'h0);
    tick();
    chk("wd_4", 32'(stall_timeout), 32'h1);
    set_req(0, 0, 0); tick(); tick();
    chk("wd_sticky", 32'(stall_timeout), 32'h1);
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    chk("wd_clr", 32'(stall_timeout), 32'h0);
    chk("cnt_clr", 32'(stall_cycles), 32'd0);

    // Counter saturation over 10 stalled cycles
    set_req(1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 6) chk("sat_6", 32'(stall_cycles), 32'd6);
    end
    chk("sat_10", 32'(stall_cycles), 32'd7);
    chk("wd_again", 32'(stall_timeout), 32'h1);
    // clr_stats beats increment and timeout set in the same cycle
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    chk("clr_prec_cnt", 32'(stall_cycles), 32'd0);
    chk("clr_prec_wd", 32'(stall_timeout), 32'h0);
    tick(); tick();
    chk("recount_2", 32'(stall_cycles), 32'd2);

    // Reset mid-count with requests still asserted
    set_req(1, 1, 1); rst = 1'b1; #1;
    chk("rst_mid_stall", 32'(stall), 32'h0);
    chk("rst_mid_flush", 32'(flush), 32'h0);
    tick();
    chk("rst_mid_cycles", 32'(stall_cycles), 32'd0);
    chk("rst_mid_state", 32'(dbg_state), 32'(CTRL_RUN));
    rst = 1'b0; set_req(0, 0, 0); tick();

    // Reset during HOLD, then a fresh RUN takes the next exception
    excp_valid = 1'b1; excp_pc = 32'h0000_0080; tick();
    excp_valid = 1'b0; #1;
    chk("pre_rst_hold", 32'(dbg_state), 32'(CTRL_HOLD));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_hold_state", 32'(dbg_state), 32'(CTRL_RUN));
    excp_valid = 1'b1; excp_pc = 32'h0000_0100; #1;
    chk("fresh_flush", 32'(flush), 32'h1);
    chk("fresh_new_pc", new_pc, 32'h100);
    tick(); excp_valid = 1'b0; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
